// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard scoreboard.
// A stage entry describes one in-flight instruction's register write.
package hazard_pkg;

  localparam int AW_DEFAULT = 3;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef struct packed {
    logic                  v;
    logic                  wr;
    logic                  load;
    logic [AW_DEFAULT-1:0] dest;
  } stage_t;

  // A write to r0 is architecturally invisible, so it never forwards or stalls.
  function automatic logic eff_wr(stage_t e);
    return e.v & e.wr & (e.dest != '0);
  endfunction

endpackage

// File: rtl/hazard_scoreboard_fwd_sel.sv
// EX operand bypass select for one source operand.
// MEM is the newer producer, so it is checked before WB.
module fwd_sel
  import hazard_pkg::*;
(
  input  logic                  ex_v_i,
  input  logic [AW_DEFAULT-1:0] src_i,
  input  logic                  use_i,
  input  stage_t                mem_i,
  input  stage_t                wb_i,
  output logic [1:0]            sel_o
);

  always_comb begin
    sel_o = FWD_RF;
    // A load in MEM has no data yet; the load-use stall keeps consumers away.
    if (ex_v_i && use_i && eff_wr(mem_i) && !mem_i.load && mem_i.dest == src_i)
      sel_o = FWD_MEM;
    else if (ex_v_i && use_i && eff_wr(wb_i) && wb_i.dest == src_i)
      sel_o = FWD_WB;
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard scoreboard: tracks EX/MEM/WB destinations, raises the
// load-use stall, selects EX operand bypasses and drives the WB write port.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int AW = AW_DEFAULT,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_valid,
  input  logic [AW-1:0] id_rs,
  input  logic [AW-1:0] id_rt,
  input  logic          id_use_rs,
  input  logic          id_use_rt,
  input  logic [AW-1:0] id_dest,
  input  logic          id_wr,
  input  logic          id_load,
  input  logic          flush,
  output logic          stall,
  output logic [1:0]    fwd_a,
  output logic [1:0]    fwd_b,
  output logic          reg_write,
  output logic [AW-1:0] wb_addr,
  output logic [CW-1:0] stall_cnt
);

  stage_t        ex_q, mem_q, wb_q, ex_d;
  logic [AW-1:0] ex_rs_q, ex_rt_q, ex_rs_d, ex_rt_d;
  logic          ex_use_rs_q, ex_use_rt_q, ex_use_rs_d, ex_use_rt_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // flush dominates: a squashed instruction cannot cause a stall.
  assign stall = id_valid & ~flush & ex_q.load & eff_wr(ex_q) &
                 ((id_use_rs & (id_rs == ex_q.dest)) |
                  (id_use_rt & (id_rt == ex_q.dest)));

  always_comb begin
    ex_d        = '0;
    ex_rs_d     = '0;
    ex_rt_d     = '0;
    ex_use_rs_d = 1'b0;
    ex_use_rt_d = 1'b0;
    if (id_valid && !stall && !flush) begin
      ex_d        = '{v: 1'b1, wr: id_wr, load: id_load, dest: id_dest};
      ex_rs_d     = id_rs;
      ex_rt_d     = id_rt;
      ex_use_rs_d = id_use_rs;
      ex_use_rt_d = id_use_rt;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stall && cnt_q != {CW{1'b1}})
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      ex_rs_q     <= '0;
      ex_rt_q     <= '0;
      ex_use_rs_q <= 1'b0;
      ex_use_rt_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      wb_q        <= mem_q;
      mem_q       <= ex_q;
      ex_q        <= ex_d;
      ex_rs_q     <= ex_rs_d;
      ex_rt_q     <= ex_rt_d;
      ex_use_rs_q <= ex_use_rs_d;
      ex_use_rt_q <= ex_use_rt_d;
      cnt_q       <= cnt_d;
    end
  end

  fwd_sel u_fwd_a (
    .ex_v_i (ex_q.v),
    .src_i  (ex_rs_q),
    .use_i  (ex_use_rs_q),
    .mem_i  (mem_q),
    .wb_i   (wb_q),
    .sel_o  (fwd_a)
  );

  fwd_sel u_fwd_b (
    .ex_v_i (ex_q.v),
    .src_i  (ex_rt_q),
    .use_i  (ex_use_rt_q),
    .mem_i  (mem_q),
    .wb_i   (wb_q),
    .sel_o  (fwd_b)
  );

  assign reg_write = eff_wr(wb_q);
  assign wb_addr   = wb_q.dest;
  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: a vector table of ID-stage
// instructions with hand-derived outputs, then a mid-stream reset sequence.
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       id_valid = 1'b0;
  logic [2:0] id_rs = '0, id_rt = '0, id_dest = '0;
  logic       id_use_rs = 1'b0, id_use_rt = 1'b0, id_wr = 1'b0, id_load = 1'b0;
  logic       flush = 1'b0;

  logic       stall, reg_write, stall2, reg_write2;
  logic [1:0] fwd_a, fwd_b, fwd_a2, fwd_b2;
  logic [2:0] wb_addr, wb_addr2;
  logic [7:0] stall_cnt;
  logic [1:0] stall_cnt2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(.AW(3), .CW(8)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dest(id_dest),
    .id_wr(id_wr), .id_load(id_load), .flush(flush), .stall(stall),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .reg_write(reg_write), .wb_addr(wb_addr),
    .stall_cnt(stall_cnt)
  );

  hazard_scoreboard #(.AW(3), .CW(2)) dut_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dest(id_dest),
    .id_wr(id_wr), .id_load(id_load), .flush(flush), .stall(stall2),
    .fwd_a(fwd_a2), .fwd_b(fwd_b2), .reg_write(reg_write2), .wb_addr(wb_addr2),
    .stall_cnt(stall_cnt2)
  );

  typedef struct {
    logic       v;
    logic [2:0] rs, rt;
    logic       urs, urt;
    logic [2:0] dest;
    logic       wr, ld, fl;
    logic       st;
    logic [1:0] fa, fb;
    logic       rw;
    logic [2:0] wa;
    int         cnt;
  } vec_t;

  vec_t tbl [39];

  function automatic vec_t mk(logic v, logic [2:0] rs, logic [2:0] rt, logic urs,
                              logic urt, logic [2:0] dest, logic wr, logic ld,
                              logic fl, logic st, logic [1:0] fa, logic [1:0] fb,
                              logic rw, logic [2:0] wa, int cnt);
    vec_t r;
    r.v = v; r.rs = rs; r.rt = rt; r.urs = urs; r.urt = urt; r.dest = dest;
    r.wr = wr; r.ld = ld; r.fl = fl; r.st = st; r.fa = fa; r.fb = fb;
    r.rw = rw; r.wa = wa; r.cnt = cnt;
    return r;
  endfunction

  function automatic vec_t nop(logic st, logic [1:0] fa, logic [1:0] fb,
                               logic rw, logic [2:0] wa, int cnt);
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, st, fa, fb, rw, wa, cnt);
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(vec_t r);
    id_valid = r.v; id_rs = r.rs; id_rt = r.rt; id_use_rs = r.urs;
    id_use_rt = r.urt; id_dest = r.dest; id_wr = r.wr; id_load = r.ld;
    flush = r.fl;
  endtask

  task automatic chk_all(string tag, logic st, logic [1:0] fa, logic [1:0] fb,
                         logic rw, logic [2:0] wa, int cnt);
    chk({tag, " stall"}, int'(stall), int'(st));
    chk({tag, " fwd_a"}, int'(fwd_a), int'(fa));
    chk({tag, " fwd_b"}, int'(fwd_b), int'(fb));
    chk({tag, " reg_write"}, int'(reg_write), int'(rw));
    if (rw) chk({tag, " wb_addr"}, int'(wb_addr), int'(wa));
    chk({tag, " stall_cnt"}, int'(stall_cnt), cnt);
    chk({tag, " stall_cnt_sat"}, int'(stall_cnt2), (cnt > 3) ? 3 : cnt);
  endtask

  initial begin
    // ALU chain: back-to-back, one between, two between
    tbl[0]  = mk(1, 1, 2, 1, 1, 3, 1, 0, 0,  0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 3, 1, 1, 1, 4, 1, 0, 0,  0, 0, 0, 0, 0, 0);
    tbl[2]  = nop(0, 1, 0, 0, 0, 0);
    tbl[3]  = mk(1, 6, 7, 1, 1, 5, 1, 0, 0,  0, 0, 0, 1, 3, 0);
    tbl[4]  = mk(1, 2, 2, 1, 1, 1, 1, 0, 0,  0, 0, 0, 1, 4, 0);
    tbl[5]  = mk(1, 5, 0, 1, 0, 2, 1, 0, 0,  0, 0, 0, 0, 0, 0);
    tbl[6]  = nop(0, 2, 0, 1, 5, 0);
    tbl[7]  = mk(1, 0, 0, 1, 1, 7, 1, 0, 0,  0, 0, 0, 1, 1, 0);
    tbl[8]  = mk(1, 0, 0, 0, 0, 6, 1, 0, 0,  0, 0, 0, 1, 2, 0);
    tbl[9]  = mk(1, 0, 0, 0, 0, 4, 1, 0, 0,  0, 0, 0, 0, 0, 0);
    tbl[10] = mk(1, 7, 7, 1, 1, 3, 1, 0, 0,  0, 0, 0, 1, 7, 0);
    tbl[11] = nop(0, 0, 0, 1, 6, 0);
    // load-use: lw r2 then add rt=r2 held for the stall cycle
    tbl[12] = mk(1, 1, 0, 1, 0, 2, 1, 1, 0,  0, 0, 0, 1, 4, 0);
    tbl[13] = mk(1, 1, 2, 1, 1, 5, 1, 0, 0,  1, 0, 0, 1, 3, 0);
    tbl[14] = mk(1, 1, 2, 1, 1, 5, 1, 0, 0,  0, 0, 0, 0, 0, 1);
    tbl[15] = nop(0, 0, 2, 1, 2, 1);
    // r0 destinations never forward, stall or write
    tbl[16] = mk(1, 1, 1, 1, 1, 0, 1, 0, 0,  0, 0, 0, 0, 0, 1);
    tbl[17] = mk(1, 0, 0, 1, 1, 6, 1, 0, 0,  0, 0, 0, 1, 5, 1);
    tbl[18] = mk(1, 0, 0, 0, 0, 0, 1, 1, 0,  0, 0, 0, 0, 0, 1);
    tbl[19] = mk(1, 0, 0, 1, 1, 1, 1, 0, 0,  0, 0, 0, 0, 0, 1);
    tbl[20] = nop(0, 0, 0, 1, 6, 1);
    tbl[21] = nop(0, 0, 0, 0, 0, 1);
    // MEM beats WB
    tbl[22] = mk(1, 0, 0, 0, 0, 4, 1, 0, 0,  0, 0, 0, 1, 1, 1);
    tbl[23] = mk(1, 0, 0, 0, 0, 4, 1, 0, 0,  0, 0, 0, 0, 0, 1);
    tbl[24] = mk(1, 4, 4, 1, 1, 7, 1, 0, 0,  0, 0, 0, 0, 0, 1);
    tbl[25] = nop(0, 1, 1, 1, 4, 1);
    // flush on the consumer of a load
    tbl[26] = mk(1, 0, 0, 0, 0, 5, 1, 1, 0,  0, 0, 0, 1, 4, 1);
    tbl[27] = mk(1, 5, 0, 1, 0, 3, 1, 0, 1,  0, 0, 0, 1, 7, 1);
    tbl[28] = nop(0, 0, 0, 0, 0, 1);
    tbl[29] = nop(0, 0, 0, 1, 5, 1);
    tbl[30] = nop(0, 0, 0, 0, 0, 1);
    // repeated load-use stalls to saturate the 2-bit counter
    tbl[31] = mk(1, 0, 0, 0, 0, 1, 1, 1, 0,  0, 0, 0, 0, 0, 1);
    tbl[32] = mk(1, 1, 0, 1, 0, 2, 1, 0, 0,  1, 0, 0, 0, 0, 1);
    tbl[33] = mk(1, 0, 0, 0, 0, 1, 1, 1, 0,  0, 0, 0, 0, 0, 2);
    tbl[34] = mk(1, 1, 0, 1, 0, 2, 1, 0, 0,  1, 0, 0, 1, 1, 2);
    tbl[35] = mk(1, 0, 0, 0, 0, 1, 1, 1, 0,  0, 0, 0, 0, 0, 3);
    tbl[36] = mk(1, 1, 0, 1, 0, 2, 1, 0, 0,  1, 0, 0, 1, 1, 3);
    tbl[37] = nop(0, 0, 0, 0, 0, 4);
    tbl[38] = nop(0, 0, 0, 1, 1, 4);

    #3;
    chk_all("por", 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 39; i++) begin
      @(posedge clk);
      #1 drive(tbl[i]);
      @(negedge clk);
      chk_all($sformatf("row%0d", i), tbl[i].st, tbl[i].fa, tbl[i].fb,
              tbl[i].rw, tbl[i].wa, tbl[i].cnt);
    end

    // fill the pipeline with live writes and a pending load-use, then reset
    @(posedge clk); #1 drive(mk(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1 drive(mk(1, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1 drive(mk(1, 4, 0, 1, 0, 6, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1 drive(mk(1, 6, 0, 1, 0, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    chk_all("pre_rst", 1, 1, 0, 1, 3, 4);
    #2 rst = 1'b1;
    #1 chk_all("async_rst", 0, 0, 0, 0, 0, 0);
    chk("async_rst wb_addr", int'(wb_addr), 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    drive(nop(0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk_all($sformatf("post_rst%0d", k), 0, 0, 0, 0, 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Pipeline controller for the 8-entry, 8-bit, 2-read/1-write register file of the pipelined MIPS core.
- Tracks in-flight destination registers through the EX, MEM and WB stages.
- Produces the ID-stage stall for load-use hazards, the EX-stage operand forwarding selects, and the register-file write enable/address for WB.
- Sits beside the ID/EX/MEM/WB pipeline registers; the pipeline datapath muxes consume its outputs.

Parameters:
- AW, 3, register address width; register 0 is hard-wired zero.
- CW, 8, width of the saturating stall counter.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  a real instruction occupies ID.
- id_rs  in  AW  ID source A address.
- id_rt  in  AW  ID source B address.
- id_use_rs  in  1  ID instruction reads rs.
- id_use_rt  in  1  ID instruction reads rt.
- id_dest  in  AW  ID destination address.
- id_wr  in  1  ID instruction writes a register.
- id_load  in  1  ID instruction is a load.
- flush  in  1  taken branch: squash the ID instruction.
- stall  out  1  hold PC and IF/ID; inject a bubble into EX.
- fwd_a  out  2  EX operand A select: 00 regfile, 01 EX/MEM result, 10 MEM/WB result.
- fwd_b  out  2  EX operand B select, same encoding.
- reg_write  out  1  register-file write enable for the WB instruction.
- wb_addr  out  AW  register-file write address.
- stall_cnt  out  CW  saturating count of stall cycles.

Behaviour:
- State: three stage entries, EX, MEM and WB.
  - Each entry holds {v, wr, load, dest}.
  - The EX entry also holds {rs, rt, use_rs, use_rt}.
- Reset (async, immediate): all entry v=0 and stall_cnt=0. As a result stall=0, fwd_a=fwd_b=00, reg_write=0, wb_addr=0.
- Effective write, for any entry: eff_wr = v & wr & (dest != 0). Writes to r0 never forward, never stall, and never assert reg_write.
- stall (combinational) = id_valid & ~flush & EX.v & EX.load & EX.eff_wr & ((id_use_rs & id_rs==EX.dest) | (id_use_rt & id_rt==EX.dest)).
- Posedge advance:
  - WB<=MEM and MEM<=EX.
  - EX<=bubble (v=0) if stall | flush | ~id_valid; otherwise EX<=the ID fields with v=1.
- Load-use penalty is exactly one stall cycle. On the next cycle the load is in MEM, which is not a load-use case, so stall deasserts and forwarding uses 10 once the load reaches WB.
  - Corrected rule: the stall repeats while the hazard persists. With the bubble inserted, the following cycle EX.v=0, so stall is always one cycle.
- fwd_a (combinational, priority order):
  - 01 if EX.v & EX.use_rs & MEM.eff_wr & ~MEM.load & MEM.dest==EX.rs.
  - else 10 if EX.v & EX.use_rs & WB.eff_wr & WB.dest==EX.rs.
  - else 00.
  - MEM is newest and wins over WB when both match.
- fwd_b: identical to fwd_a using rt/use_rt.
- A load in MEM never selects 01, because its data is not yet available. The load-use stall guarantees this case cannot arise for a dependent instruction.
- reg_write = WB.eff_wr; wb_addr = WB.dest. The register file writes on negedge, so the ID read in the same cycle sees the new value and no ID-stage bypass is needed.
- stall_cnt increments by 1 on each posedge with stall=1 and saturates at 2^CW-1 (no wrap).
- flush and hazard in the same cycle: flush wins, giving stall=0 and a bubble into EX. The older entries still advance normally.
- rst mid-operation clears all in-flight entries. Instructions squashed by reset never write.

Decomposition:
- Shared package hazard_pkg holds:
  - FWD_RF=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10.
  - The stage-entry struct typedef {v, wr, load, dest}.
  - AW_DEFAULT=3.
- One natural sub-module: fwd_sel, instantiated twice (operands A and B). It takes the EX source/use, MEM entry and WB entry and returns the 2-bit select.

Test Plan:
- Reset: assert rst mid-stream with entries valid → stall=0, fwd=00, reg_write=0, stall_cnt=0 immediately, before any clock edge.
- ALU chain:
  - Drive "add r3<-..." then "sub rs=r3" on back-to-back cycles.
  - → fwd_a=01 in the sub's EX cycle.
  - One independent instruction between them → fwd_a=10.
  - Two instructions between them → fwd_a=00.
- Load-use:
  - Drive "lw r2" then "add rt=r2".
  - → stall=1 for exactly one cycle and stall_cnt=1.
  - The add's EX then shows fwd_b=10; reg_write=1 with wb_addr=2 when the lw reaches WB.
- r0 destination: "add r0<-..." followed by "add rs=r0"; also "lw r0" followed by a use of r0 → fwd_a=00, stall=0, reg_write=0.
- Priority: "add r4", "add r4", "or rs=r4" → fwd_a=01 (the MEM entry wins over WB).
- flush during hazard: lw r5 then a consumer of r5 with flush=1 → stall=0, EX bubble, no forwarding or writes from the squashed instruction. Also hold the hazard repeatedly with CW=2 → stall_cnt saturates at 3.
